lfsr_xor_descrambler: RTL
=========================

// Module: lfsr_xor_descrambler
// PURPOSE
//  Additive (XOR) stream descrambler: XORs each accepted W-bit beat with the next W bits of a
//  7-bit LFSR keystream (x^7+x^6+1). Receive-side counterpart of the team's XOR scrambler.
//  Sits on a valid/ready stream between the line deframer and the payload sink.
//  Frame start (up_sof) reloads the LFSR seed.
// PARAMETERS
//  W     8      data bits per beat, 1..32
//  SEED  7'h7F  LFSR load value applied at every up_sof beat and at reset
// PORTS
//  clk         in   1  clock, all logic on posedge
//  rst         in   1  synchronous, active-high reset
//  up_valid    in   1  input beat valid
//  up_sof      in   1  input beat is first of frame; sampled only when valid
//  up_data     in   W  scrambled input data
//  up_ready    out  1  block can accept a beat this cycle
//  down_valid  out  1  output beat valid
//  down_data   out  W  descrambled output data
//  down_ready  in   1  sink accepts the output beat
// BEHAVIOUR
//  - Reset: down_valid=0, down_data=0, LFSR state s=SEED.
//    up_ready=1 in the first cycle after reset.
//  - Input handshake: accept = up_valid & up_ready.
//    Output handshake: take = down_valid & down_ready.
//  - up_ready = !down_valid | down_ready. This is a combinational pass of down_ready.
//    There is a single output register and no skid buffer.
//  - Latency: 1 cycle from accept to down_valid=1.
//    Back-to-back full throughput while down_ready=1.
//  - Keystream step: k = s[6]^s[5]; s <= {s[5:0],k}; k is the keystream bit.
//  - Per accepted beat:
//    - Base state b = SEED if up_sof, else the current s.
//    - Generate W steps from b. Step i (i=0 first) gives bit ks[i].
//    - down_data <= up_data ^ ks. s <= state after W steps.
//  - The W steps are unrolled combinationally in one cycle. No multi-cycle iteration.
//  - No accept: s holds. Output held stable while down_valid & !down_ready.
//  - take without accept: down_valid <= 0. Accept and take in the same cycle: new beat replaces the old.
//  - SEED=0: the LFSR stays at 0 and data passes unchanged. This is legal and defined.
//  - up_sof on a non-accepted cycle is ignored. It has no effect on s.
//  - rst mid-stream: the pending output is dropped (down_valid=0) and s=SEED.
// CONFIGURATION
//  LFSR_XOR_DESCRAMBLER_BEAT_CNT_EN defined:
//    - Adds output port beat_cnt [15:0]: count of beats accepted in the current frame.
//    - Reset 0. On an accepted sof beat -> 1. On other accepted beats +1, saturating at 16'hFFFF.
//    - Updates in the same cycle as down_data.
//  Not defined: port and counter absent. Datapath identical.
// TESTING (W=8, SEED=7'h7F)
//  1 Reset, then sof beat 8'h00 then beat 8'h00, down_ready=1
//    -> outputs 8'h40 then 8'h30, each 1 cycle after its accept.
//  2 sof beat 8'h40 then beat 8'h30 -> 8'h00, 8'h00 (round-trip vs scrambler).
//  3 Frame of 2 beats (8'h00,8'h00), then new sof beat 8'h00 -> third output 8'h40 (seed reload).
//  4 down_ready=0 for 3 cycles with down_valid=1
//    -> up_ready=0, down_data stable, s unchanged; later beats are correct once released.
//  5 Assert rst while down_valid=1 mid-frame, then non-sof beat 8'h00 -> 8'h40 (s back to SEED).
//  6 With BEAT_CNT_EN: sof + 4 beats -> beat_cnt 1,2,3,4,5; next sof -> 1.

Source files
------------

// File: rtl/lfsr_xor_descrambler.sv
// Additive descrambler: XORs each accepted beat with W keystream bits of a x^7+x^6+1 LFSR.
// Optional per-frame beat counter enabled by LFSR_XOR_DESCRAMBLER_BEAT_CNT_EN.
module lfsr_xor_descrambler #(
    parameter int unsigned W    = 8,
    parameter logic [6:0]  SEED = 7'h7F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    input  logic         up_sof,
    input  logic [W-1:0] up_data,
    output logic         up_ready,
    output logic         down_valid,
    output logic [W-1:0] down_data,
    input  logic         down_ready
`ifdef LFSR_XOR_DESCRAMBLER_BEAT_CNT_EN
    ,
    output logic [15:0]  beat_cnt
`endif
);

    logic [6:0]   s_q;
    logic [6:0]   s_d;
    logic [6:0]   lfsr_st;
    logic [W-1:0] ks;
    logic         accept;
    logic         take;

    assign up_ready = !down_valid || down_ready;
    assign accept   = up_valid && up_ready;
    assign take     = down_valid && down_ready;

    // All W keystream steps are unrolled in one cycle; bit i comes from step i.
    always_comb begin
        lfsr_st = up_sof ? SEED : s_q;
        ks      = '0;
        for (int i = 0; i < int'(W); i++) begin
            ks[i]   = lfsr_st[6] ^ lfsr_st[5];
            lfsr_st = {lfsr_st[5:0], lfsr_st[6] ^ lfsr_st[5]};
        end
        s_d = lfsr_st;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= SEED;
            down_valid <= 1'b0;
            down_data  <= '0;
        end else if (accept) begin
            s_q        <= s_d;
            down_valid <= 1'b1;
            down_data  <= up_data ^ ks;
        end else if (take) begin
            down_valid <= 1'b0;
        end
    end

`ifdef LFSR_XOR_DESCRAMBLER_BEAT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= 16'd0;
        end else if (accept) begin
            if (up_sof) begin
                beat_cnt <= 16'd1;
            end else if (beat_cnt != 16'hFFFF) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
